// File: rtl/snn_layer.sv
// Time-multiplexed fully-connected integrate-and-fire layer with run-time weights.
// Optional leak on non-firing membranes when SPIKER_LEAK_EN is defined.
module snn_layer #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned W_W        = 8,
    parameter int unsigned V_W        = 12,
    parameter int unsigned THRESH     = 64,
    parameter int unsigned N_CYCLES   = 10,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic                               ready,
    output logic                               sample,
    input  logic                               sample_ready,
    input  logic [N_IN-1:0]                    in_spikes,
    output logic [N_OUT-1:0]                   out_spikes,
    output logic                               out_valid,
    output logic                               done,
    input  logic                               w_we,
    input  logic [$clog2(N_IN*N_OUT)-1:0]      w_addr,
    input  logic signed [W_W-1:0]              w_data
);

    localparam int unsigned NW = N_IN * N_OUT;
    localparam int unsigned AW = $clog2(N_IN * N_OUT);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [V_W-1:0] V_MAX = {1'b0, {(V_W-1){1'b1}}};
    localparam logic signed [V_W-1:0] V_MIN = {1'b1, {(V_W-1){1'b0}}};
    localparam logic signed [V_W-1:0] THR   = V_W'(THRESH);
    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(N_CYCLES - 1);
    localparam logic [IW-1:0]         LAST_IDX  = IW'(N_IN - 1);

    if (V_W <= W_W || THRESH == 0 || THRESH >= (1 << (V_W - 1)) ||
        (1 << CNT_W) <= N_CYCLES || LEAK_SHIFT >= V_W) begin : g_param_check
        $error("snn_layer: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_REQ, S_WAIT, S_ACC, S_FIRE} state_e;

    state_e                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic                     sample_q, sample_d;
    logic [N_OUT-1:0]         out_spikes_q, out_spikes_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;
    logic [CNT_W-1:0]         step_q, step_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [N_IN-1:0]          in_q, in_d;
    logic signed [V_W-1:0]    v_q [N_OUT];
    logic signed [V_W-1:0]    v_d [N_OUT];
    logic signed [W_W-1:0]    w_q [NW];
    logic signed [W_W-1:0]    w_d [NW];
    logic signed [V_W-1:0]    acc_c [N_OUT];
    logic                     addr_ok_c;

    // Out-of-range addresses can only exist when NW is not a power of two.
    if (NW == (1 << AW)) begin : g_addr_full
        assign addr_ok_c = 1'b1;
    end else begin : g_addr_part
        assign addr_ok_c = (w_addr < AW'(NW));
    end

    function automatic logic signed [V_W-1:0] sat_add(input logic signed [V_W-1:0] a,
                                                      input logic signed [W_W-1:0] b);
        logic signed [V_W:0] s;
        s = (V_W+1)'(a) + (V_W+1)'(b);
        if (s[V_W] != s[V_W-1]) return s[V_W] ? V_MIN : V_MAX;
        return s[V_W-1:0];
    endfunction

    // Membrane values after adding the current input's weights (if that input spiked).
    always_comb begin : acc_comb
        for (int j = 0; j < N_OUT; j++) begin
            acc_c[j] = v_q[j];
            if (in_q[idx_q]) acc_c[j] = sat_add(v_q[j], w_q[AW'(int'(idx_q) * N_OUT + j)]);
        end
    end

    always_comb begin : next_comb
        state_d      = state_q;
        out_spikes_d = out_spikes_q;
        out_valid_d  = 1'b0;
        done_d       = 1'b0;
        step_d       = step_q;
        idx_d        = idx_q;
        in_d         = in_q;
        v_d          = v_q;
        w_d          = w_q;

        if (state_q == S_IDLE && w_we && addr_ok_c) w_d[w_addr] = w_data;

        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (start) begin
                    for (int j = 0; j < N_OUT; j++) v_d[j] = '0;
                    out_spikes_d = '0;
                    step_d       = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (sample_ready) begin
                    in_d    = in_spikes;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (idx_q == LAST_IDX) begin
                    // Threshold decision folded into the last accumulate so spikes show during FIRE.
                    for (int j = 0; j < N_OUT; j++) begin
                        if (acc_c[j] >= THR) begin
                            out_spikes_d[j] = 1'b1;
                            v_d[j]          = '0;
                        end else begin
                            out_spikes_d[j] = 1'b0;
`ifdef SPIKER_LEAK_EN
                            v_d[j]          = acc_c[j] - (acc_c[j] >>> LEAK_SHIFT);
`else
                            v_d[j]          = acc_c[j];
`endif
                        end
                    end
                    out_valid_d = 1'b1;
                    done_d      = (step_q == LAST_STEP);
                    state_d     = S_FIRE;
                end else begin
                    v_d   = acc_c;
                    idx_d = idx_q + IW'(1);
                end
            end
            S_FIRE: begin
                if (step_q == LAST_STEP) begin
                    state_d = S_IDLE;
                end else begin
                    step_d  = step_q + CNT_W'(1);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_INIT;
        endcase

        ready_d  = (state_d == S_IDLE);
        sample_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_ff
        if (!rst_n) begin
            state_q      <= S_INIT;
            ready_q      <= 1'b0;
            sample_q     <= 1'b0;
            out_spikes_q <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            step_q       <= '0;
            idx_q        <= '0;
            in_q         <= '0;
            for (int j = 0; j < N_OUT; j++) v_q[j] <= '0;
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            sample_q     <= sample_d;
            out_spikes_q <= out_spikes_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            step_q       <= step_d;
            idx_q        <= idx_d;
            in_q         <= in_d;
            v_q          <= v_d;
            w_q          <= w_d;
        end
    end

    assign ready      = ready_q;
    assign sample     = sample_q;
    assign out_spikes = out_spikes_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;

endmodule

// File: doc/snn_layer.md
# snn_layer

Parametrised, time-multiplexed fully-connected layer of integrate-and-fire neurons. It generalises the fixed 4-input / 2-output spiking network to arbitrary input and output counts, with run-time-loadable signed weights, saturating membranes and an optional leak. It keeps the same start / ready / sample / sample_ready handshake, so it can replace the fixed network under the same stimulus controller.

## Interface
- N_IN, 4: input spike channels.
- N_OUT, 2: neurons, one output spike channel each.
- W_W, 8: signed weight width.
- V_W, 12: signed membrane width. Must satisfy V_W > W_W.
- THRESH, 64: firing threshold. Positive, below 2^(V_W-1).
- N_CYCLES, 10: time steps per run.
- CNT_W, 5: step counter width. Must satisfy 2^CNT_W > N_CYCLES.
- LEAK_SHIFT, 4: leak divisor exponent. Used only with leak compiled in.

Ports (AW = $clog2(N_IN*N_OUT)):
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- ready  out  1  block idle, start accepted.
- sample  out  1  one-cycle request for a new input vector.
- sample_ready  in  1  in_spikes valid.
- in_spikes  in  N_IN  input spike vector.
- out_spikes  out  N_OUT  spikes from the latest time step.
- out_valid  out  1  one-cycle pulse; out_spikes just updated.
- done  out  1  one-cycle pulse on the last step of a run.
- w_we  in  1  weight write enable.
- w_addr  in  AW  weight index = i*N_OUT + j (input i to neuron j).
- w_data  in  W_W  signed weight.

## Operation
- FSM states: INIT, IDLE, REQ, WAIT, ACC, FIRE.
- INIT: reset state. Moves to IDLE on the next edge.
- IDLE: ready=1.
  - start=1: clear all membranes, clear out_spikes, clear the step counter, then go to REQ.
- REQ: sample=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - sample_ready=1: latch in_spikes, set idx=0, go to ACC.
  - sample_ready=0: stall indefinitely. sample stays 0 and is not re-issued.
- ACC: one input per cycle, idx = 0..N_IN-1.
  - If latched bit idx=1, every neuron j does v[j] += weight[idx][j].
  - Sums saturate to [-2^(V_W-1), 2^(V_W-1)-1].
  - After idx = N_IN-1, go to FIRE.
- FIRE: for each neuron j:
  - v[j] >= THRESH: out_spikes[j]=1 and v[j]=0.
  - Otherwise: out_spikes[j]=0 and v[j] is kept (leak rules under Configuration).
  - out_valid=1 in this cycle.
  - If step == N_CYCLES-1: done=1 and go to IDLE. Otherwise increment the step counter and go to REQ.
- Weights:
  - N_IN*N_OUT registers, reset to 0.
  - A write with w_we=1 is applied only while ready=1; writes in other states are ignored.
  - w_addr >= N_IN*N_OUT is ignored.
- out_spikes holds its value between FIRE cycles and is cleared on an accepted start.

## Timing
- Reset values:
  - Outputs: ready=0, sample=0, out_spikes=0, out_valid=0, done=0.
  - Internal: membranes 0, weights 0, state INIT.
- ready rises on the first edge after rst_n deasserts and is registered.
- Start to first sample: 1 cycle. With sample_ready held high, one step is N_IN+3 cycles; a run is N_CYCLES*(N_IN+3) cycles.
- done coincides with the last out_valid.
- start held high continuously: ready=1 for exactly one cycle between runs.
- w_we and start in the same IDLE cycle: the write is applied and used by that run.
- start outside IDLE is ignored.
- rst_n asserted mid-run: immediate return to reset values, including weights. No partial output.

## Configuration
- SPIKER_LEAK_EN defined: in FIRE, each non-firing neuron does v[j] = v[j] - (v[j] >>> LEAK_SHIFT), an arithmetic shift.
- SPIKER_LEAK_EN undefined: a non-firing membrane is held unchanged and LEAK_SHIFT is unused.

## Test plan
All tests use the defaults unless stated.
- Reset: ready=0 while rst_n=0 and 1 one cycle after release; sample, out_spikes, out_valid and done all 0.
- Basic run: weights 32 to neuron 0 and 0 to neuron 1, in_spikes=4'hF, start → 10 out_valid pulses, each with out_spikes=2'b01. Steps are 7 cycles apart; done on the 10th pulse; then ready=1.
- Saturation: all weights -128, in_spikes=4'hF, leak off → v[j] = -512, -1024, -1536, then clamped at -2048 from step 4 on (checked hierarchically). No spikes.
- Stall: hold sample_ready=0 for 5 cycles after sample → single sample pulse, no ACC progress, that step takes 12 cycles. Weight writes in this window leave the weights unchanged.
- Leak: weight[0][0]=16, all others 0, in_spikes=4'h1:
  - Without SPIKER_LEAK_EN: out_spikes[0]=1 on the 4th out_valid.
  - With it: membrane 15, 30, 44, 57, then 73 fires, so the spike is on the 5th out_valid.
- Reset mid-run: assert rst_n=0 during ACC of step 3 → outputs return to reset values and weights to 0. The next run with no reloads produces no spikes.
